// File: rtl/serial_tx_pkg.sv
// Shared types and sizing helpers for the serial word transmitter.
package serial_tx_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam int unsigned DEF_WIDTH = 8;

  // Counter width for a word of w bits, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

  localparam int unsigned CNT_W = cnt_width(DEF_WIDTH);

endpackage

// File: rtl/serial_twos_comp_cell.sv
// LSB-first two's-complement cell: bits pass until the first 1 has gone by,
// after which every bit is inverted when negation is requested.
module serial_twos_comp_cell (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  input  logic advance,
  input  logic neg,
  input  logic bit_in,
  output logic bit_out
);

  logic seen_one;
  logic seen_eff;

  // A clear lands on the same cycle as the new word's first bit, so it masks the stale flag.
  always_comb begin
    seen_eff = 1'b0;
    if (clear) begin
      seen_eff = 1'b0;
    end else begin
      seen_eff = seen_one;
    end
    bit_out = bit_in ^ (neg & seen_eff);
  end

  // Remember whether a 1 has already been emitted in the current word.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      seen_one <= 1'b0;
    end else if (advance) begin
      seen_one <= seen_eff | bit_in;
    end else begin
      seen_one <= seen_one;
    end
  end

endmodule

// File: rtl/serial_word_tx.sv
// Parallel-to-serial word transmitter, LSB first, with frame/last qualifiers.
// Optional NEG_TX_EN adds neg_in to transmit the two's complement of the word.
module serial_word_tx
  import serial_tx_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] data_in,
`ifdef NEG_TX_EN
  input  logic             neg_in,
`endif
  output logic             x_out,
  output logic             frame_out,
  output logic             last_out
);

  localparam int unsigned CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    bit_cnt;
  logic [CW-1:0]    next_cnt;
  logic [WIDTH-1:0] shift_reg;
  logic             accept;
  logic             raw_bit;
  logic             tx_bit;

  assign load_ready = (state == ST_IDLE) | ((state == ST_SHIFT) & last_out);
  assign accept     = load_valid & load_ready;

  // Pick the bit that will appear on x_out after the next edge.
  always_comb begin
    next_cnt = bit_cnt + CW'(1);
    raw_bit  = 1'b0;
    if (accept) begin
      raw_bit = data_in[0];
    end else begin
      raw_bit = shift_reg[next_cnt];
    end
  end

`ifdef NEG_TX_EN
  logic neg_reg;
  logic neg_eff;
  logic advance;

  always_comb begin
    neg_eff = 1'b0;
    if (accept) begin
      neg_eff = neg_in;
    end else begin
      neg_eff = neg_reg;
    end
    advance = accept | ((state == ST_SHIFT) & ~last_out);
  end

  // Negate request is captured with the word and held for its whole frame.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      neg_reg <= 1'b0;
    end else if (accept) begin
      neg_reg <= neg_in;
    end else begin
      neg_reg <= neg_reg;
    end
  end

  serial_twos_comp_cell u_comp (
    .clk     (clk),
    .rstn    (rstn),
    .clear   (accept),
    .advance (advance),
    .neg     (neg_eff),
    .bit_in  (raw_bit),
    .bit_out (tx_bit)
  );
`else
  assign tx_bit = raw_bit;
`endif

  // Transmit FSM with registered serial outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      shift_reg <= '0;
      x_out     <= 1'b0;
      frame_out <= 1'b0;
      last_out  <= 1'b0;
    end else if (accept) begin
      // A new word may start straight out of idle or back-to-back after the last bit.
      state     <= ST_SHIFT;
      bit_cnt   <= '0;
      shift_reg <= data_in;
      x_out     <= tx_bit;
      frame_out <= 1'b1;
      last_out  <= 1'b0;
    end else begin
      case (state)
        ST_SHIFT: begin
          if (!last_out) begin
            state     <= ST_SHIFT;
            bit_cnt   <= next_cnt;
            shift_reg <= shift_reg;
            x_out     <= tx_bit;
            frame_out <= 1'b1;
            last_out  <= (next_cnt == LAST_CNT);
          end else begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            shift_reg <= shift_reg;
            x_out     <= 1'b0;
            frame_out <= 1'b0;
            last_out  <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          bit_cnt   <= '0;
          shift_reg <= shift_reg;
          x_out     <= 1'b0;
          frame_out <= 1'b0;
          last_out  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_word_tx.sv
// Randomized self-checking bench for serial_word_tx against a word-level stream model.
module tb_serial_word_tx;

  localparam int W = 8;

  logic         clk;
  logic         rstn;
  logic         load_valid;
  logic         load_ready;
  logic [W-1:0] data_in;
`ifdef NEG_TX_EN
  logic         neg_in;
`endif
  logic         x_out;
  logic         frame_out;
  logic         last_out;

  int tests;
  int fails;

  serial_word_tx #(.WIDTH(W)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .data_in    (data_in),
`ifdef NEG_TX_EN
    .neg_in     (neg_in),
`endif
    .x_out      (x_out),
    .frame_out  (frame_out),
    .last_out   (last_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word actually put on the wire: the value itself or its two's complement.
  function automatic logic [W-1:0] tx_word(input logic [W-1:0] w, input logic n);
    logic [W-1:0] r;
    r = n ? W'(~w + W'(1)) : w;
    return r;
  endfunction

  task automatic test_reset();
    logic [3:0] got;
    rstn = 1'b0;
    load_valid = 1'b0;
    data_in = 8'h00;
`ifdef NEG_TX_EN
    neg_in = 1'b0;
`endif
    #1;
    got = {frame_out, x_out, last_out, load_ready};
    tests++;
    if (got !== 4'b0001) begin
      fails++;
      $display("FAIL reset_state got f/x/l/r=%b required 0001", got);
    end
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_single(input string name, input logic [W-1:0] w, input logic n);
    logic [W-1:0] e;
    logic [3:0]   got;
    logic [3:0]   req;
    e = tx_word(w, n);
    @(negedge clk);
    load_valid = 1'b1;
    data_in = w;
`ifdef NEG_TX_EN
    neg_in = n;
`endif
    tests++;
    if (load_ready !== 1'b1) begin
      fails++;
      $display("FAIL %s ready_before_load got %b required 1", name, load_ready);
    end
    @(negedge clk);
    load_valid = 1'b0;
    data_in = W'($urandom);
    for (int i = 0; i < W; i++) begin
      got = {frame_out, x_out, last_out, load_ready};
      req = {1'b1, e[i], (i == W - 1), (i == W - 1)};
      tests++;
      if (got !== req) begin
        fails++;
        $display("FAIL %s bit%0d got f/x/l/r=%b required %b", name, i, got, req);
      end
      @(negedge clk);
    end
    got = {frame_out, x_out, last_out, load_ready};
    tests++;
    if (got !== 4'b0001) begin
      fails++;
      $display("FAIL %s idle_after got f/x/l/r=%b required 0001", name, got);
    end
  endtask

  task automatic test_back_to_back(input int nwords, input logic [W-1:0] w0, input logic [W-1:0] w1);
    logic [W-1:0] words[$];
    logic         expq[$];
    logic [3:0]   got;
    logic [3:0]   req;
    int           k;
    words.push_back(w0);
    words.push_back(w1);
    for (int i = 2; i < nwords; i++) words.push_back(W'($urandom));
    foreach (words[j]) for (int b = 0; b < W; b++) expq.push_back(words[j][b]);
    @(negedge clk);
    load_valid = 1'b1;
    data_in = words[0];
    k = 1;
    for (int c = 0; c < nwords * W; c++) begin
      @(negedge clk);
      got = {frame_out, x_out, last_out, load_ready};
      req = {1'b1, expq[c], (c % W == W - 1), (c % W == W - 1)};
      tests++;
      if (got !== req) begin
        fails++;
        $display("FAIL back_to_back cycle%0d got f/x/l/r=%b required %b", c, got, req);
      end
      if (c % W == W - 1) begin
        if (k < nwords) begin
          data_in = words[k];
          k++;
        end else begin
          load_valid = 1'b0;
        end
      end else begin
        data_in = W'($urandom);
      end
    end
    @(negedge clk);
    got = {frame_out, x_out, last_out, load_ready};
    tests++;
    if (got !== 4'b0001) begin
      fails++;
      $display("FAIL back_to_back idle_after got f/x/l/r=%b required 0001", got);
    end
  endtask

  task automatic test_ignore_busy(input logic [W-1:0] w, input logic [W-1:0] intruder);
    logic [3:0] got;
    logic [3:0] req;
    @(negedge clk);
    load_valid = 1'b1;
    data_in = w;
    @(negedge clk);
    load_valid = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (i == 3) begin
        load_valid = 1'b1;
        data_in = intruder;
      end else begin
        load_valid = 1'b0;
      end
      got = {frame_out, x_out, last_out, load_ready};
      req = {1'b1, w[i], (i == W - 1), (i == W - 1)};
      tests++;
      if (got !== req) begin
        fails++;
        $display("FAIL ignore_busy bit%0d got f/x/l/r=%b required %b", i, got, req);
      end
      @(negedge clk);
    end
    load_valid = 1'b0;
    got = {frame_out, x_out, last_out, load_ready};
    tests++;
    if (got !== 4'b0001) begin
      fails++;
      $display("FAIL ignore_busy idle_after got f/x/l/r=%b required 0001", got);
    end
  endtask

  task automatic test_async_reset(input logic [W-1:0] w);
    logic [3:0] got;
    @(negedge clk);
    load_valid = 1'b1;
    data_in = w;
    @(negedge clk);
    load_valid = 1'b0;
    repeat (3) @(negedge clk);
    // Assert reset mid-low-phase, well before the next rising edge.
    #2;
    rstn = 1'b0;
    #1;
    got = {frame_out, x_out, last_out, load_ready};
    tests++;
    if (got !== 4'b0001) begin
      fails++;
      $display("FAIL async_reset got f/x/l/r=%b required 0001", got);
    end
    @(negedge clk);
    rstn = 1'b1;
    test_single("after_reset_0F", 8'h0F, 1'b0);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_single("load_B4", 8'hB4, 1'b0);
    for (int i = 0; i < 5; i++) test_single("random_word", W'($urandom), 1'b0);
    test_back_to_back(2, 8'h01, 8'hFF);
    test_back_to_back(5, W'($urandom), W'($urandom));
    test_ignore_busy(8'hB4, 8'h55);
    test_ignore_busy(W'($urandom), W'($urandom));
    test_async_reset(8'hB4);
`ifdef NEG_TX_EN
    test_single("neg_14", 8'h14, 1'b1);
    test_single("neg_00", 8'h00, 1'b1);
    test_single("neg_80", 8'h80, 1'b1);
    for (int i = 0; i < 5; i++) test_single("random_neg", W'($urandom), 1'($urandom_range(0, 1)));
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
